// File: rtl/score_display_mux_if.sv
// Load/convert handshake bundle for score_display_mux.
// master drives value+load; slave returns busy+overflow.
interface score_display_mux_if #(
  parameter int BIN_W = 16
);
  logic [BIN_W-1:0] value;
  logic             load;
  logic             busy;
  logic             overflow;

  modport master (
    output value,
    output load,
    input  busy,
    input  overflow
  );

  modport slave (
    input  value,
    input  load,
    output busy,
    output overflow
  );
endinterface

// File: rtl/score_display_mux.sv
// Binary score -> BCD (double-dabble) -> multiplexed 7-seg display.
// Ports: clk, reset (sync, active-high), bus (slave), an, seg, dp.
module score_display_mux #(
  parameter int NUM_DIGITS    = 4,
  parameter int BIN_W         = 16,
  parameter int REFRESH_DIV   = 100000,
  parameter int BLANK_LEADING = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  score_display_mux_if.slave    bus,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int SW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] COMMIT  = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(BIN_W - 1);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  localparam logic [NUM_DIGITS-1:0] AN_RST = ~(NUM_DIGITS'(1));

  localparam logic [6:0] SEG_ZERO  = 7'b0000001;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic [1:0]       state;
  logic [BIN_W-1:0] cap;
  logic [CW-1:0]    cnt;
  logic [SW-1:0]    scratch;
  logic [SW-1:0]    adj;
  logic             pend;
  logic [SW-1:0]    disp;
  logic             ovf;

  logic [RW-1:0]    rcnt;
  logic [IW-1:0]    idx;

  logic [NUM_DIGITS-1:0] zero_above;
  logic [3:0]            cur;
  logic                  blank;
  logic [NUM_DIGITS-1:0] nxt_an;
  logic [6:0]            nxt_seg;

  function automatic logic [6:0] seg_of(
    input logic [3:0] d
  );
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Add-3 correction ahead of the shift.
  always_comb begin
    adj = scratch;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (scratch[4*k +: 4] >= 4'd5)
        adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cap     <= '0;
      cnt     <= '0;
      scratch <= '0;
      pend    <= 1'b0;
      disp    <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load) begin
            cap     <= bus.value;
            cnt     <= '0;
            scratch <= '0;
            pend    <= 1'b0;
            state   <= CONVERT;
          end
        end
        CONVERT: begin
          // A 1 leaving the top nibble means the
          // value needs more digits than we have.
          scratch <= {adj[SW-2:0], cap[BIN_W-1]};
          pend    <= pend | adj[SW-1];
          cap     <= cap << 1;
          cnt     <= cnt + 1'b1;
          if (cnt == CNT_LAST)
            state <= COMMIT;
        end
        COMMIT: begin
          disp  <= scratch;
          ovf   <= pend;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt <= '0;
      idx  <= '0;
    end else if (rcnt == REF_LAST) begin
      rcnt <= '0;
      if (idx == IDX_LAST)
        idx <= '0;
      else
        idx <= idx + 1'b1;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  // zero_above[k]: digits k..top are all zero.
  always_comb begin
    logic all_zero;
    all_zero   = 1'b1;
    zero_above = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      all_zero      = all_zero & (disp[4*k +: 4] == 4'd0);
      zero_above[k] = all_zero;
    end
  end

  always_comb begin
    cur   = disp[4*idx +: 4];
    blank = (BLANK_LEADING != 0) && !ovf
            && (idx != '0) && zero_above[idx];
    nxt_an = '1;
    if (!blank)
      nxt_an[idx] = 1'b0;
    if (ovf)
      nxt_seg = SEG_DASH;
    else if (blank)
      nxt_seg = SEG_BLANK;
    else
      nxt_seg = seg_of(cur);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= AN_RST;
      seg <= SEG_ZERO;
    end else begin
      an  <= nxt_an;
      seg <= nxt_seg;
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.overflow = ovf;
  assign dp           = 1'b1;

endmodule

// File: tb/tb_score_display_mux.sv
// Self-checking bench for score_display_mux.
// Two DUTs (blanking on/off) share all stimulus.
module tb_score_display_mux;
  localparam int ND   = 4;
  localparam int BW   = 16;
  localparam int DIV  = 4;
  localparam int MAXV = 9999;

  localparam logic [6:0] SEG_TAB [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010,
    7'b0000110, 7'b1001100, 7'b0100100,
    7'b0100000, 7'b0001111, 7'b0000000,
    7'b0000100
  };

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  score_display_mux_if #(.BIN_W(BW)) bus1 ();
  score_display_mux_if #(.BIN_W(BW)) bus0 ();

  logic [ND-1:0] an1, an0;
  logic [6:0]    seg1, seg0;
  logic          dp1, dp0;

  score_display_mux #(
    .NUM_DIGITS(ND), .BIN_W(BW),
    .REFRESH_DIV(DIV), .BLANK_LEADING(1)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus1),
    .an(an1), .seg(seg1), .dp(dp1)
  );

  score_display_mux #(
    .NUM_DIGITS(ND), .BIN_W(BW),
    .REFRESH_DIV(DIV), .BLANK_LEADING(0)
  ) dut0 (
    .clk(clk), .reset(reset), .bus(bus0),
    .an(an0), .seg(seg0), .dp(dp0)
  );

  // Clock edges seen since the last reset edge.
  int n;
  always @(posedge clk) begin
    if (reset) n <= 0;
    else       n <= n + 1;
  end

  int errors = 0;
  int checks = 0;
  int unsigned shown = 0;

  task automatic drive(input logic ld, input int unsigned v);
    bus1.load  = ld;
    bus1.value = BW'(v);
    bus0.load  = ld;
    bus0.value = BW'(v);
  endtask

  // Expected {an,seg} for blank-on then blank-off DUT,
  // given the committed value and edge count.
  function automatic logic [21:0] exp_disp(
    input int unsigned v, input int cyc
  );
    int i;
    int unsigned p, d;
    logic [ND-1:0] a;
    logic [6:0] s;
    i = (cyc == 0) ? 0 : ((cyc - 1) / DIV) % ND;
    p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    d = (v / p) % 10;
    a = '1;
    a[i] = 1'b0;
    if (v > MAXV) return {a, 7'h7E, a, 7'h7E};
    s = SEG_TAB[d];
    if (i > 0 && v < p) return {4'hF, 7'h7F, a, s};
    return {a, s, a, s};
  endfunction

  task automatic load_value(input int unsigned v, input string tag);
    int cnt;
    @(negedge clk);
    drive(1'b1, v);
    @(negedge clk);
    drive(1'b0, $urandom);
    cnt = 0;
    while (bus1.busy && cnt < 100) begin
      checks++;
      if ({an1, seg1, an0, seg0} !== exp_disp(shown, n)) begin
        errors++;
        $display("FAIL %s hold: got %b/%b %b/%b want %b",
                 tag, an1, seg1, an0, seg0, exp_disp(shown, n));
      end
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt != BW + 1) begin
      errors++;
      $display("FAIL %s busy_len: got %0d want %0d", tag, cnt, BW + 1);
    end
    shown = v;
  endtask

  task automatic check_display(input string tag);
    @(negedge clk);
    checks++;
    if (bus1.overflow !== (shown > MAXV)) begin
      errors++;
      $display("FAIL %s overflow: got %b want %b",
               tag, bus1.overflow, shown > MAXV);
    end
    for (int c = 0; c < 2 * ND * DIV; c++) begin
      checks++;
      if ({an1, seg1, an0, seg0} !== exp_disp(shown, n)) begin
        errors++;
        $display("FAIL %s scan n=%0d: got %b/%b %b/%b want %b",
                 tag, n, an1, seg1, an0, seg0, exp_disp(shown, n));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    drive(1'b0, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({an1, seg1, bus1.busy, bus1.overflow, dp1} !==
        {4'b1110, 7'b0000001, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset: got an=%b seg=%b busy=%b ovf=%b dp=%b",
               an1, seg1, bus1.busy, bus1.overflow, dp1);
    end
    reset = 1'b0;
    shown = 0;
    check_display("reset_scan");
  endtask

  task automatic test_directed();
    int unsigned vals [6] = '{1234, 7, 10000, 9999, 0, 65535};
    foreach (vals[k]) begin
      load_value(vals[k], $sformatf("dir%0d", vals[k]));
      check_display($sformatf("dir%0d", vals[k]));
    end
  endtask

  task automatic test_random();
    int unsigned v;
    for (int k = 0; k < 8; k++) begin
      v = (k % 3 == 0) ? $urandom_range(0, 99)
                       : $urandom_range(0, 65535);
      load_value(v, $sformatf("rnd%0d", v));
      check_display($sformatf("rnd%0d", v));
    end
  endtask

  task automatic test_back_to_back();
    int cnt;
    @(negedge clk);
    drive(1'b1, 5);
    @(negedge clk);
    cnt = 0;
    while (bus1.busy && cnt < 100) begin
      if (cnt == 0 || cnt == 4) drive(1'b1, 42);
      else drive(1'b0, $urandom_range(100, 65535));
      cnt++;
      @(negedge clk);
    end
    drive(1'b0, 0);
    checks++;
    if (cnt != BW + 1) begin
      errors++;
      $display("FAIL b2b busy_len: got %0d want %0d", cnt, BW + 1);
    end
    repeat (3) begin
      checks++;
      if (bus1.busy !== 1'b0) begin
        errors++;
        $display("FAIL b2b extra_conv: got busy=%b want 0", bus1.busy);
      end
      @(negedge clk);
    end
    shown = 5;
    check_display("b2b");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive(1'b1, 1234);
    @(negedge clk);
    drive(1'b0, 0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 77);
    @(negedge clk);
    checks++;
    if ({bus1.busy, bus1.overflow, an1, seg1} !==
        {1'b0, 1'b0, 4'b1110, 7'b0000001}) begin
      errors++;
      $display("FAIL rst_mid: got busy=%b ovf=%b an=%b seg=%b",
               bus1.busy, bus1.overflow, an1, seg1);
    end
    reset = 1'b0;
    drive(1'b0, 0);
    shown = 0;
    check_display("rst_mid_zero");
    load_value(88, "after_rst");
    check_display("after_rst");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
